// File: rtl/gps_speed_pkg.sv
// gps_speed_pkg: FSM states, ASCII/arithmetic constants and digit helpers
// shared by the GPS speed-over-ground to mph converter.
package gps_speed_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PARSE, S_SCALE, S_DIV, S_OUT} state_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;

    localparam logic [6:0] SCALE_K = 7'd115;
    localparam logic [6:0] DIV_100 = 7'd100;
    localparam logic [6:0] DIV_10  = 7'd10;

    function automatic logic is_digit(input logic [7:0] c);
        return c >= ASCII_0 && c <= ASCII_9;
    endfunction

    // A non-digit reads as 0 so an absent trailing fraction digit (',' or blank) adds nothing.
    function automatic logic [3:0] dval(input logic [7:0] c);
        return is_digit(c) ? 4'(c - ASCII_0) : 4'd0;
    endfunction
endpackage

// File: rtl/serial_div.sv
// serial_div: restoring divider, one quotient bit per cycle after a one-cycle load.
// done, quot and rem describe the iteration that completes at the coming edge.
module serial_div #(
    parameter int DIV_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [6:0]       divisor,
    output logic             done,
    output logic [DIV_W-1:0] quot,
    output logic [6:0]       rem
);
    localparam int CW = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] q_q, q_d;
    logic [6:0]       r_q, r_d, d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       trial;
    logic             ge;

    always_comb begin
        trial = {r_q, q_q[DIV_W-1]};
        ge    = trial >= {1'b0, d_q};
        q_d   = q_q;
        r_d   = r_q;
        d_d   = d_q;
        cnt_d = cnt_q;
        if (start) begin
            q_d   = dividend;
            r_d   = '0;
            d_d   = divisor;
            cnt_d = CW'(DIV_W);
        end else if (cnt_q != '0) begin
            q_d   = {q_q[DIV_W-2:0], ge};
            r_d   = ge ? 7'(trial - {1'b0, d_q}) : trial[6:0];
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign done = !start && cnt_q == CW'(1);
    assign quot = q_d;
    assign rem  = r_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            r_q   <= r_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/speed_conv_ctrl.sv
// speed_conv_ctrl: parses an ASCII knots field, converts to mph x100 and BCD digits
// through one shared serial divider, with a one-deep overwrite-on-full request buffer.
module speed_conv_ctrl
    import gps_speed_pkg::*;
#(
    parameter int DIV_W = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       speed_ready,
    input  logic [7:0] spd0,
    input  logic [7:0] spd1,
    input  logic [7:0] spd2,
    input  logic [7:0] spd3,
    input  logic [7:0] spd4,
    input  logic [7:0] spd5,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       fmt_err,
    output logic [3:0] mph_d4,
    output logic [3:0] mph_d3,
    output logic [3:0] mph_d2,
    output logic [3:0] mph_d1,
    output logic [3:0] mph_d0,
    output logic [13:0] mph_x100_out,
    output logic       busy,
    output logic [7:0] drop_cnt
);
    state_t           state_q, state_d;
    logic [4:0][7:0]  spd_in, cap_q, cap_d, pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [7:0]       drop_q, drop_d;
    logic [13:0]      knots, knots_q, knots_d;
    logic             bad;
    logic [DIV_W-1:0] prod_q, prod_d, quot_w_q, quot_w_d;
    logic             kick_q, kick_d;
    logic [2:0]       op_q, op_d;
    logic [13:0]      mph_w_q, mph_w_d, mph_o_q, mph_o_d;
    logic [2:0][3:0]  dig_w_q, dig_w_d;
    logic [4:0][3:0]  dig_o_q, dig_o_d;
    logic             err_q, err_d;
    logic             hs, take, stash, step, last;
    logic             div_start, div_done;
    logic [DIV_W-1:0] div_quot;
    logic [6:0]       div_rem;

    assign spd_in = {spd4, spd3, spd2, spd1, spd0};
    assign hs     = state_q == S_OUT && out_ready;
    assign take   = (state_q == S_IDLE && speed_ready) || (hs && (pend_full_q || speed_ready));
    assign stash  = speed_ready && state_q != S_IDLE && !(hs && !pend_full_q);
    assign step   = state_q == S_DIV && div_done;
    assign last   = step && op_q == 3'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = speed_ready ? S_PARSE : S_IDLE;
            S_PARSE: state_d = bad ? S_OUT : S_SCALE;
            S_SCALE: state_d = S_DIV;
            S_DIV:   state_d = last ? S_OUT : S_DIV;
            S_OUT:   state_d = !out_ready ? S_OUT : take ? S_PARSE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = state_q == S_OUT;
        busy      = state_q != S_IDLE && state_q != S_OUT;
        div_start = kick_q;
    end

    // D.DD when the dot is second, DD.D[D] when it is third; anything else is rejected.
    always_comb begin
        bad = cap_q[1] == ASCII_DOT ? !(is_digit(cap_q[0]) && is_digit(cap_q[2])) :
              cap_q[2] == ASCII_DOT ? !(is_digit(cap_q[0]) && is_digit(cap_q[1]) && is_digit(cap_q[3])) :
              1'b1;
        knots = cap_q[1] == ASCII_DOT ?
                14'(dval(cap_q[0])) * 14'd100 + 14'(dval(cap_q[2])) * 14'd10 + 14'(dval(cap_q[3])) :
                14'(dval(cap_q[0])) * 14'd1000 + 14'(dval(cap_q[1])) * 14'd100 +
                14'(dval(cap_q[3])) * 14'd10 + 14'(dval(cap_q[4]));
    end

    always_comb begin
        cap_d       = cap_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        drop_d      = drop_q;
        knots_d     = knots_q;
        prod_d      = prod_q;
        kick_d      = state_q == S_SCALE || (step && op_q != 3'd4);
        op_d        = op_q;
        quot_w_d    = quot_w_q;
        mph_w_d     = mph_w_q;
        dig_w_d     = dig_w_q;
        err_d       = err_q;
        mph_o_d     = mph_o_q;
        dig_o_d     = dig_o_q;
        if (take) cap_d = (hs && pend_full_q) ? pend_q : spd_in;
        if (hs) pend_full_d = 1'b0;
        if (stash) begin
            pend_d      = spd_in;
            pend_full_d = 1'b1;
            if (pend_full_q && !hs && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
        if (state_q == S_PARSE) knots_d = knots;
        if (state_q == S_SCALE) begin
            prod_d = DIV_W'(knots_q) * DIV_W'(SCALE_K);
            op_d   = '0;
        end
        // Op 0 yields mph x100; ops 1..4 peel decimal digits off the running quotient.
        if (step) begin
            op_d     = op_q + 3'd1;
            quot_w_d = div_quot;
            if (op_q == 3'd0) mph_w_d = 14'(div_quot);
            else if (op_q != 3'd4) dig_w_d[2'(op_q - 3'd1)] = 4'(div_rem);
        end
        if (state_q == S_PARSE && bad) begin
            err_d   = 1'b1;
            mph_o_d = '0;
            dig_o_d = '0;
        end
        if (last) begin
            err_d   = 1'b0;
            mph_o_d = mph_w_q;
            dig_o_d = {4'(div_quot), 4'(div_rem), dig_w_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            drop_q      <= '0;
            knots_q     <= '0;
            prod_q      <= '0;
            kick_q      <= 1'b0;
            op_q        <= '0;
            quot_w_q    <= '0;
            mph_w_q     <= '0;
            dig_w_q     <= '0;
            err_q       <= 1'b0;
            mph_o_q     <= '0;
            dig_o_q     <= '0;
        end else begin
            cap_q       <= cap_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            drop_q      <= drop_d;
            knots_q     <= knots_d;
            prod_q      <= prod_d;
            kick_q      <= kick_d;
            op_q        <= op_d;
            quot_w_q    <= quot_w_d;
            mph_w_q     <= mph_w_d;
            dig_w_q     <= dig_w_d;
            err_q       <= err_d;
            mph_o_q     <= mph_o_d;
            dig_o_q     <= dig_o_d;
        end
    end

    serial_div #(.DIV_W(DIV_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (op_q == 3'd0 ? prod_q : quot_w_q),
        .divisor  (op_q == 3'd0 ? DIV_100 : DIV_10),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    assign fmt_err      = err_q;
    assign mph_x100_out = mph_o_q;
    assign {mph_d4, mph_d3, mph_d2, mph_d1, mph_d0} = dig_o_q;
    assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_speed_conv_ctrl.sv
// tb_speed_conv_ctrl: scoreboard bench; requests are modelled at issue time and
// a negedge monitor compares every presented result in order.
module tb_speed_conv_ctrl;
    logic        clk = 0, rst_n = 0, speed_ready = 0, out_ready = 1;
    logic [7:0]  spd0 = 8'h20, spd1 = 8'h20, spd2 = 8'h20, spd3 = 8'h20, spd4 = 8'h20, spd5 = 8'h20;
    logic        out_valid, fmt_err, busy;
    logic [3:0]  mph_d4, mph_d3, mph_d2, mph_d1, mph_d0;
    logic [13:0] mph_x100_out;
    logic [7:0]  drop_cnt;

    typedef struct {
        logic        err;
        int          mph;
        logic [19:0] dig;
    } exp_t;

    int          checks = 0, errors = 0, cyc = 0, drop_exp = 0;
    exp_t        sb[$];
    bit          taken = 0, prev_hs = 0;
    logic [34:0] held, cur;
    exp_t        me;
    logic [7:0]  mb [6];

    speed_conv_ctrl #(.DIV_W(21)) dut (
        .clk(clk), .rst_n(rst_n), .speed_ready(speed_ready),
        .spd0(spd0), .spd1(spd1), .spd2(spd2), .spd3(spd3), .spd4(spd4), .spd5(spd5),
        .out_ready(out_ready), .out_valid(out_valid), .fmt_err(fmt_err),
        .mph_d4(mph_d4), .mph_d3(mph_d3), .mph_d2(mph_d2), .mph_d1(mph_d1), .mph_d0(mph_d0),
        .mph_x100_out(mph_x100_out), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit isd(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    // Knots = integer digits before the dot, then two fraction places (second optional).
    function automatic exp_t ref_model(input logic [7:0] b [6]);
        exp_t e;
        int   dot, k, m;
        e.err = 0; e.mph = 0; e.dig = '0;
        dot = b[1] == 8'h2E ? 1 : b[2] == 8'h2E ? 2 : -1;
        if (dot < 0 || !isd(b[dot + 1])) begin e.err = 1; return e; end
        k = 0;
        for (int i = 0; i < dot; i++) begin
            if (!isd(b[i])) begin e.err = 1; return e; end
            k = k * 10 + int'(b[i]) - 48;
        end
        k = k * 100 + (int'(b[dot + 1]) - 48) * 10 + (isd(b[dot + 2]) ? int'(b[dot + 2]) - 48 : 0);
        e.mph = k * 115 / 100;
        m = e.mph;
        for (int i = 0; i < 5; i++) begin
            e.dig[4 * i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            drop_exp = 0;
            taken = 0;
            prev_hs = 0;
        end else begin
            cur = {fmt_err, mph_x100_out, mph_d4, mph_d3, mph_d2, mph_d1, mph_d0};
            if (prev_hs) chk("valid_after_handshake", out_valid, 0);
            if (out_valid && !taken) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got out_valid=1 expected no result outstanding");
                end else begin
                    chk("fmt_err", fmt_err, sb[0].err);
                    chk("mph_x100", mph_x100_out, sb[0].mph);
                    chk("digits", {mph_d4, mph_d3, mph_d2, mph_d1, mph_d0}, sb[0].dig);
                    chk("drop_cnt", drop_cnt, drop_exp);
                end
                held = cur;
                taken = 1;
            end else if (out_valid) chk("hold_stable", cur, held);
            if (out_valid) chk("busy_in_out", busy, 0);
            prev_hs = out_valid && out_ready;
            if (prev_hs) begin
                if (sb.size() > 0) void'(sb.pop_front());
                taken = 0;
            end
            if (speed_ready) begin
                mb = '{spd0, spd1, spd2, spd3, spd4, spd5};
                me = ref_model(mb);
                if (sb.size() < 2) sb.push_back(me);
                else begin
                    sb[1] = me;
                    drop_exp = drop_exp < 255 ? drop_exp + 1 : 255;
                end
            end
        end
    end

    task automatic send(input string s, output int n);
        logic [7:0] b [6];
        for (int i = 0; i < 6; i++) b[i] = i < s.len() ? s[i] : 8'h20;
        @(posedge clk); #2;
        {spd0, spd1, spd2, spd3, spd4, spd5} = {b[0], b[1], b[2], b[3], b[4], b[5]};
        speed_ready = 1;
        @(posedge clk); #1;
        n = cyc;
        #1 speed_ready = 0;
    endtask

    task automatic wait_valid(input int n, input int lat, input string nm);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (seen) chk(nm, cyc - n, lat);
        else begin
            checks++; errors++;
            $display("FAIL %s: got no out_valid expected valid after %0d edges", nm, lat);
        end
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            idle = !busy && !out_valid && sb.size() == 0 && !speed_ready;
        end
        if (!idle) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy=%0d queued=%0d expected idle", busy, sb.size());
        end
    endtask

    task automatic rand_req();
        logic [7:0] b [6];
        string      pool = "0123456789.,A ";
        int         f = $urandom_range(0, 4);
        for (int i = 0; i < 6; i++) b[i] = 8'h30 + 8'($urandom_range(0, 9));
        case (f)
            0: b[1] = 8'h2E;
            1: begin b[2] = 8'h2E; b[4] = $urandom_range(0, 1) ? 8'h2C : 8'h20; end
            2: b[2] = 8'h2E;
            3: for (int i = 0; i < 6; i++) b[i] = pool[$urandom_range(0, 13)];
            default: begin b[2] = 8'h2E; b[$urandom_range(0, 5)] = 8'h41; end
        endcase
        {spd0, spd1, spd2, spd3, spd4, spd5} = {b[0], b[1], b[2], b[3], b[4], b[5]};
    endtask

    initial begin
        int n;
        bit low;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fmt_err", fmt_err, 0);
        chk("rst_mph", mph_x100_out, 0);
        chk("rst_digits", {mph_d4, mph_d3, mph_d2, mph_d1, mph_d0}, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1;

        send("12.34 ", n);
        wait_valid(n, 112, "latency_12_34");
        chk("mph_12_34", mph_x100_out, 1419);
        chk("dig_12_34", {mph_d4, mph_d3, mph_d2, mph_d1, mph_d0}, 20'h01419);
        wait_idle();
        send("99.99,", n);
        wait_valid(n, 112, "latency_99_99");
        chk("mph_99_99", mph_x100_out, 11498);
        chk("dig_99_99", {mph_d4, mph_d3, mph_d2, mph_d1, mph_d0}, 20'h11498);
        wait_idle();
        send("0.00  ", n);
        wait_valid(n, 112, "latency_0_00");
        chk("mph_0_00", mph_x100_out, 0);
        wait_idle();
        send("1A.2  ", n);
        wait_valid(n, 1, "latency_fmt");
        chk("fmt_1A_2", fmt_err, 1);
        chk("dig_fmt", {mph_d4, mph_d3, mph_d2, mph_d1, mph_d0}, 0);
        wait_idle();

        send("1.23  ", n);
        repeat (10) @(posedge clk);
        send("45.6,x", n);
        repeat (10) @(posedge clk);
        send("7.89  ", n);
        wait_idle();
        chk("drop_three_strobes", drop_cnt, 1);

        @(posedge clk); #2 out_ready = 0;
        send("7.25  ", n);
        wait_valid(n, 112, "latency_hold");
        repeat (50) begin
            @(negedge clk);
            chk("held_valid", out_valid, 1);
        end
        chk("held_mph", mph_x100_out, 833);
        @(posedge clk); #2 out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("released_valid", out_valid, 0);
        wait_idle();

        send("12.34 ", n);
        repeat (39) @(posedge clk);
        #2 rst_n = 0;
        @(posedge clk); #2 rst_n = 1;
        low = 1;
        repeat (150) begin
            @(negedge clk);
            if (out_valid || busy) low = 0;
        end
        chk("abandoned_quiet", low, 1);
        chk("abandoned_drop", drop_cnt, 0);
        send("5.00  ", n);
        wait_valid(n, 112, "latency_after_reset");
        chk("mph_5_00", mph_x100_out, 575);
        wait_idle();

        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #2;
            out_ready = $urandom_range(0, 3) != 0;
            speed_ready = $urandom_range(0, 70) == 0;
            if (speed_ready) rand_req();
        end
        @(posedge clk); #2;
        speed_ready = 0;
        out_ready = 1;
        wait_idle();
        chk("drop_final", drop_cnt, drop_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
